register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
Parametrised successor to the single-issue 32x32 register file, for the pipelined RV32I core. Provides NRD combinational read ports and one write port. Adds a per-register busy scoreboard for pending-writeback hazard detection. Adds a sequential bulk-clear engine so the core can zero architectural state without asserting reset. Sits between decode (reads, claims) and writeback (writes).

Parameters:
XLEN, 32, register data width
NREGS, 32, number of architectural registers; power of two, at least 4
NRD, 2, number of read ports, at least 1
ARGV_REG, 10, index of the register loaded with ARGV_VAL on reset and on clear
ARGV_VAL, 0, reset/clear value of ARGV_REG
(localparam AW = $clog2(NREGS))

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
rd_data  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
rd_busy  out  NRD  port i's addressed register has a claimed, unretired write
wr_ena  in  1  writeback enable
wr_addr  in  AW  writeback register
wr_data  in  XLEN  writeback data
claim_ena  in  1  decode issued an instruction that will write claim_addr
claim_addr  in  AW  destination being claimed
clr_req  in  1  start bulk clear (single-cycle pulse or level)
clr_busy  out  1  bulk clear in progress

Behaviour:
- Reset (async, active-high):
  - All registers 0, except ARGV_REG = ARGV_VAL.
  - All busy bits 0; FSM in IDLE; clr_busy 0; clear counter 0.
- Register 0:
  - Reads always return 0; rd_busy for address 0 is always 0.
  - Writes and claims to address 0 are ignored.
- Reads: combinational from stored state, zero-cycle latency. rd_busy[i] = busy[rd_addr i], combinational.
- Write: when wr_ena is high and wr_addr != 0, the register takes wr_data at the clock edge and busy[wr_addr] clears.
- Claim: when claim_ena is high and claim_addr != 0, busy[claim_addr] sets at the clock edge.
- Same-edge claim and write to the same address:
  - Data is written.
  - busy ends at 1; the claim wins, because it belongs to a newer instruction.
- Write to a register that is not busy is legal; data is written and busy stays 0.
- FSM states:
  - IDLE:
    - clr_busy = 0.
    - clr_req -> CLEAR with counter = 1.
  - CLEAR:
    - clr_busy = 1.
    - Each cycle, reg[counter] <= (counter == ARGV_REG ? ARGV_VAL : 0) and busy[counter] <= 0; counter increments.
    - When counter == NREGS-1 is processed, -> IDLE.
    - Total NREGS-1 cycles with clr_busy high; clr_busy is a registered output.
  - While in CLEAR:
    - wr_ena, claim_ena and clr_req are ignored.
    - Reads remain live and return a mix of cleared and uncleared values.
  - clr_req asserted in the same cycle as a write or claim while IDLE: the write/claim takes effect and the FSM enters CLEAR. Register 1 is cleared on the next cycle.
- Reset asserted mid-clear: immediate return to full reset state and IDLE; no partial state is kept.
- The counter is AW bits wide; it never wraps, because exit happens at NREGS-1.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: if wr_ena is high, wr_addr != 0 and wr_addr == rd_addr i, rd_data i returns wr_data in the same cycle. rd_busy i is forced to 0 unless claim_ena targets the same address in that cycle. Bypass is disabled while clr_busy = 1.
- Undefined: reads return the stored value only; new data is visible the cycle after the write edge.

Decomposition:
- Package regfile_pkg:
  - State enum typedef (IDLE, CLEAR), 1 bit.
  - Default XLEN/NREGS constants.
  - ABI register index constants (ZERO=0, RA=1, SP=2, A0=10).
- Sub-module regfile_clear_seq: FSM plus counter. Outputs clr_busy, clr_addr and clr_we, which the top-level muxes into the write path.
- Storage is a flop array built with a generate loop of the existing register module (enable plus reset value). No inferred RAM.

Test Plan:
- Reset with ARGV_VAL=32'h5 -> reg10 reads 5; all other registers and all rd_busy read 0; clr_busy 0.
- Claim x3, then next cycle read x3 on port 1 -> rd_busy[1]=1; write x3=32'hDEAD_BEEF -> next cycle rd_data=DEADBEEF, rd_busy=0.
- Same-edge claim x7 and write x7=32'h1234 -> x7 reads 1234 and busy[7]=1.
- Write x0=32'hFFFF_FFFF and claim x0 -> x0 reads 0 and busy 0 on every port.
- Fill x1..x31 with their index, pulse clr_req -> clr_busy high for exactly 31 cycles. Afterwards all registers read 0 except x10=ARGV_VAL. A write issued mid-clear has no effect.
- Assert rst at clear cycle 5 -> clr_busy drops immediately; all registers are at reset values. With REGFILE_BYPASS_EN defined, write x4=9 while reading x4 -> rd_data=9 in the same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded RV32I register file.
// The optional write-to-read bypass is selected by the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_A0   = 10;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback-facing bus of the register file.
// The master side is the core pipeline; the slave side is the register file.
import regfile_pkg::*;

interface register_file_sb_if #(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NREGS = DEFAULT_NREGS,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_ena;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                claim_ena;
    logic [AW-1:0]       claim_addr;
    logic                clr_req;
    logic                clr_busy;

    modport master (
        output rd_addr, wr_ena, wr_addr, wr_data, claim_ena, claim_addr, clr_req,
        input  rd_data, rd_busy, clr_busy
    );

    modport slave (
        input  rd_addr, wr_ena, wr_addr, wr_data, claim_ena, claim_addr, clr_req,
        output rd_data, rd_busy, clr_busy
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks registers 1..NREGS-1, one per cycle, after a clear request.
import regfile_pkg::*;

module regfile_clear_seq #(
    parameter int NREGS = DEFAULT_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr_req,
    output logic          o_clr_busy,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_clr_we
);

    clr_state_t    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;

    // Register 0 is hardwired, so the walk starts at 1 and exits after NREGS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= AW'(1);
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_cnt == AW'(NREGS - 1)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_busy = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/regfile_reg.sv
// Single architectural register: load enable plus a per-instance reset value.
module regfile_reg #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= RESET_VAL;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port register file with busy scoreboard and sequential bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
import regfile_pkg::*;

module register_file_sb #(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              NREGS    = DEFAULT_NREGS,
    parameter int              NRD      = 2,
    parameter int              ARGV_REG = REG_A0,
    parameter logic [XLEN-1:0] ARGV_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    register_file_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic            w_clr_busy;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic [XLEN-1:0] w_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NRD*XLEN-1:0] w_rd_data;
    logic [NRD-1:0]      w_rd_busy;

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (bus.clr_req),
        .o_clr_busy (w_clr_busy),
        .o_clr_addr (w_clr_addr),
        .o_clr_we   (w_clr_we)
    );

    assign w_regs[0] = '0;

    // The clear engine owns the write path while it runs; writeback is ignored then.
    for (genvar g = 1; g < NREGS; g++) begin : g_reg
        localparam logic [XLEN-1:0] RV = (g == ARGV_REG) ? ARGV_VAL : '0;
        logic            w_en;
        logic [XLEN-1:0] w_d;

        assign w_en = w_clr_we ? (w_clr_addr == AW'(g))
                               : (bus.wr_ena && (bus.wr_addr == AW'(g)));
        assign w_d  = w_clr_we ? RV : bus.wr_data;

        regfile_reg #(
            .W         (XLEN),
            .RESET_VAL (RV)
        ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_en),
            .i_d  (w_d),
            .o_q  (w_regs[g])
        );
    end

    // A same-edge claim beats the write because it belongs to a newer instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (w_clr_we) begin
                    if (w_clr_addr == AW'(i))
                        r_busy[i] <= 1'b0;
                end else if (bus.claim_ena && (bus.claim_addr == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (bus.wr_ena && (bus.wr_addr == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            w_rd_data[p*XLEN +: XLEN] = w_regs[bus.rd_addr[p*AW +: AW]];
            w_rd_busy[p]              = r_busy[bus.rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (!w_clr_busy && bus.wr_ena && (bus.wr_addr != '0) &&
                (bus.wr_addr == bus.rd_addr[p*AW +: AW])) begin
                w_rd_data[p*XLEN +: XLEN] = bus.wr_data;
                w_rd_busy[p] = bus.claim_ena && (bus.claim_addr == bus.wr_addr);
            end
`endif
        end
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_busy  = w_rd_busy;
    assign bus.clr_busy = w_clr_busy;

endmodule
